// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared writeback types and register-file constants
package core_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_SREGS  = 32;
    localparam int XLEN       = 32;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_LSU,
        WB_MDU
    } wb_src_e;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/sreg_scoreboard.sv
// rtl/sreg_scoreboard.sv - pending-destination bitmap with dup detection and rs query
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   set_i, set_rd_i  mark a destination as pending (issue of LSU/MDU op)
//   clr_i, clr_rd_i  retire a pending destination (LSU/MDU writeback grant)
//   rs1_i, rs2_i     decode-stage source queries
//   rs_busy_o        either source pending (from registered bitmap)
//   busy_vec_o       registered bitmap
//   dup_err_o        registered pulse: set hit an already-pending, uncleared bit
module sreg_scoreboard
    import core_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_i,
    input  logic [REG_ADDR_W-1:0] set_rd_i,
    input  logic                  clr_i,
    input  logic [REG_ADDR_W-1:0] clr_rd_i,
    input  logic [REG_ADDR_W-1:0] rs1_i,
    input  logic [REG_ADDR_W-1:0] rs2_i,
    output logic                  rs_busy_o,
    output logic [NUM_SREGS-1:0]  busy_vec_o,
    output logic                  dup_err_o
);

    logic [NUM_SREGS-1:0] busy_q;
    logic [NUM_SREGS-1:0] busy_d;
    logic [NUM_SREGS-1:0] set_mask;
    logic [NUM_SREGS-1:0] clr_mask;
    logic                 set_eff;
    logic                 dup_d;
    logic                 dup_q;

    always_comb begin
        // x0 is hardwired zero, so it can never be pending.
        set_eff  = set_i && (set_rd_i != '0);
        set_mask = '0;
        clr_mask = '0;
        if (set_eff) set_mask[set_rd_i] = 1'b1;
        if (clr_i)   clr_mask[clr_rd_i] = 1'b1;
        // Set is applied after clear so a same-cycle re-issue stays pending.
        busy_d = (busy_q & ~clr_mask) | set_mask;
        dup_d  = set_eff && busy_q[set_rd_i] && !(clr_i && (clr_rd_i == set_rd_i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            dup_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            dup_q  <= dup_d;
        end
    end

    // No bypass of a same-cycle clear: the registered write port plus the
    // regfile write-through already covers that cycle.
    assign rs_busy_o  = busy_q[rs1_i] | busy_q[rs2_i];
    assign busy_vec_o = busy_q;
    assign dup_err_o  = dup_q;

endmodule

// File: rtl/sreg_wb_arbiter.sv
// rtl/sreg_wb_arbiter.sv - writeback arbiter merging ALU/LSU/MDU onto the regfile write port
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   alu_/lsu_/mdu_ valid/ready    per-producer result handshake
//   alu_/lsu_/mdu_ rd/data        per-producer destination and result
//   busy_set_i, busy_rd_i         issue-stage dispatch of a long-latency op
//   rs1_addr_i, rs2_addr_i        decode-stage hazard query
//   rs_busy_o, busy_vec_o         scoreboard query result and bitmap
//   dup_err_o                     duplicate pending-destination pulse
//   regw_en_o, rd_addr_o, rd_data_o  registered regfile write port
module sreg_wb_arbiter
    import core_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid_i,
    output logic                  alu_ready_o,
    input  logic [4:0]            alu_rd_i,
    input  logic [DATA_WIDTH-1:0] alu_data_i,
    input  logic                  lsu_valid_i,
    output logic                  lsu_ready_o,
    input  logic [4:0]            lsu_rd_i,
    input  logic [DATA_WIDTH-1:0] lsu_data_i,
    input  logic                  mdu_valid_i,
    output logic                  mdu_ready_o,
    input  logic [4:0]            mdu_rd_i,
    input  logic [DATA_WIDTH-1:0] mdu_data_i,
    input  logic                  busy_set_i,
    input  logic [4:0]            busy_rd_i,
    input  logic [4:0]            rs1_addr_i,
    input  logic [4:0]            rs2_addr_i,
    output logic                  rs_busy_o,
    output logic [31:0]           busy_vec_o,
    output logic                  dup_err_o,
    output logic                  regw_en_o,
    output logic [4:0]            rd_addr_o,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam int CNT_W = 4;

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             starve_q, starve_d;
    logic             pref_lsu_q, pref_lsu_d;   // 1: LSU wins an LSU/MDU tie
    logic             alu_win;
    logic             slow_grant;
    wb_src_e          grant_src;
    wb_req_t          grant_req;

    // Readies are functions of valids and state only. ALU is ready unless
    // starved-out; LSU/MDU are ready unless the ALU takes the port or the
    // other slow producer holds round-robin priority.
    always_comb begin
        alu_win     = alu_valid_i && !starve_q;
        alu_ready_o = !starve_q;
        lsu_ready_o = !alu_win && (!mdu_valid_i || pref_lsu_q);
        mdu_ready_o = !alu_win && (!lsu_valid_i || !pref_lsu_q);

        grant_src = WB_NONE;
        grant_req = '0;
        if (alu_win) begin
            grant_src = WB_ALU;
            grant_req = '{valid: 1'b1, rd: alu_rd_i, data: alu_data_i};
        end else if (lsu_valid_i && lsu_ready_o) begin
            grant_src = WB_LSU;
            grant_req = '{valid: 1'b1, rd: lsu_rd_i, data: lsu_data_i};
        end else if (mdu_valid_i && mdu_ready_o) begin
            grant_src = WB_MDU;
            grant_req = '{valid: 1'b1, rd: mdu_rd_i, data: mdu_data_i};
        end
        slow_grant = (grant_src == WB_LSU) || (grant_src == WB_MDU);
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        starve_d     = starve_q;
        pref_lsu_d   = pref_lsu_q;

        if (slow_grant || (!lsu_valid_i && !mdu_valid_i)) begin
            starve_cnt_d = '0;
            starve_d     = 1'b0;
        end else if (grant_src == WB_ALU) begin
            // The flag blocks further ALU grants, so the counter cannot pass the limit.
            starve_cnt_d = starve_cnt_q + 1'b1;
            starve_d     = (starve_cnt_d == CNT_W'(STARVE_LIMIT));
        end

        if (grant_src == WB_LSU) pref_lsu_d = 1'b0;
        if (grant_src == WB_MDU) pref_lsu_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
            starve_q     <= 1'b0;
            pref_lsu_q   <= 1'b1;
            regw_en_o    <= 1'b0;
            rd_addr_o    <= '0;
            rd_data_o    <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            starve_q     <= starve_d;
            pref_lsu_q   <= pref_lsu_d;
            if (grant_req.valid) begin
                // x0 grants are consumed but never written.
                regw_en_o <= (grant_req.rd != '0);
                rd_addr_o <= grant_req.rd;
                rd_data_o <= grant_req.data;
            end else begin
                regw_en_o <= 1'b0;
            end
        end
    end

    sreg_scoreboard u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_i      (busy_set_i),
        .set_rd_i   (busy_rd_i),
        .clr_i      (slow_grant),
        .clr_rd_i   (grant_req.rd),
        .rs1_i      (rs1_addr_i),
        .rs2_i      (rs2_addr_i),
        .rs_busy_o  (rs_busy_o),
        .busy_vec_o (busy_vec_o),
        .dup_err_o  (dup_err_o)
    );

endmodule

// File: tb/tb_sreg_wb_arbiter.sv
// tb/tb_sreg_wb_arbiter.sv - directed self-checking bench for sreg_wb_arbiter
module tb_sreg_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid_i = 1'b0, lsu_valid_i = 1'b0, mdu_valid_i = 1'b0;
    logic        alu_ready_o, lsu_ready_o, mdu_ready_o;
    logic [4:0]  alu_rd_i = '0, lsu_rd_i = '0, mdu_rd_i = '0;
    logic [31:0] alu_data_i = '0, lsu_data_i = '0, mdu_data_i = '0;
    logic        busy_set_i = 1'b0;
    logic [4:0]  busy_rd_i = '0, rs1_addr_i = '0, rs2_addr_i = '0;
    logic        rs_busy_o, dup_err_o, regw_en_o;
    logic [31:0] busy_vec_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sreg_wb_arbiter #(.DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
        .mdu_valid_i(mdu_valid_i), .mdu_ready_o(mdu_ready_o), .mdu_rd_i(mdu_rd_i), .mdu_data_i(mdu_data_i),
        .busy_set_i(busy_set_i), .busy_rd_i(busy_rd_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rs_busy_o(rs_busy_o), .busy_vec_o(busy_vec_o), .dup_err_o(dup_err_o),
        .regw_en_o(regw_en_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid_i = 1'b0; lsu_valid_i = 1'b0; mdu_valid_i = 1'b0;
        busy_set_i  = 1'b0; rs1_addr_i  = '0;   rs2_addr_i  = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        step(); step();
        checks++;
        if (regw_en_o !== 1'b0 || rd_addr_o !== 5'd0 || rd_data_o !== 32'd0) begin
            failures++;
            $display("FAIL reset_wport got en=%b addr=%0d data=%h exp en=0 addr=0 data=0", regw_en_o, rd_addr_o, rd_data_o);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (busy_vec_o !== 32'd0 || dup_err_o !== 1'b0 || rs_busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_sb got busy=%h dup=%b rs=%b exp 0/0/0", busy_vec_o, dup_err_o, rs_busy_o);
        end
        checks++;
        if (alu_ready_o !== 1'b1 || regw_en_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got alu_ready=%b en=%b exp 1/0", alu_ready_o, regw_en_o);
        end
    endtask

    task automatic test_alu_only();
        alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 32'hDEADBEEF;
        #1;
        checks++;
        if (alu_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL alu_ready got %b exp 1", alu_ready_o);
        end
        step();
        alu_valid_i = 1'b0;
        checks++;
        if (regw_en_o !== 1'b1 || rd_addr_o !== 5'd5 || rd_data_o !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL alu_write got en=%b addr=%0d data=%h exp 1/5/deadbeef", regw_en_o, rd_addr_o, rd_data_o);
        end
        step();
        checks++;
        if (regw_en_o !== 1'b0 || rd_addr_o !== 5'd5 || rd_data_o !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL alu_hold got en=%b addr=%0d data=%h exp 0/5/deadbeef", regw_en_o, rd_addr_o, rd_data_o);
        end
    endtask

    task automatic test_lsu_mdu_rr();
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd3; lsu_data_i = 32'h0000_0033;
        mdu_valid_i = 1'b1; mdu_rd_i = 5'd4; mdu_data_i = 32'h0000_0044;
        #1;
        checks++;
        if (lsu_ready_o !== 1'b1 || mdu_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL rr_first got lsu=%b mdu=%b exp 1/0", lsu_ready_o, mdu_ready_o);
        end
        step();
        lsu_data_i = 32'h0000_0035;   // LSU re-presents a new result; MDU still waiting
        #1;
        checks++;
        if (lsu_ready_o !== 1'b0 || mdu_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL rr_second got lsu=%b mdu=%b exp 0/1", lsu_ready_o, mdu_ready_o);
        end
        checks++;
        if (regw_en_o !== 1'b1 || rd_addr_o !== 5'd3 || rd_data_o !== 32'h33) begin
            failures++;
            $display("FAIL rr_wr_x3 got en=%b addr=%0d data=%h exp 1/3/33", regw_en_o, rd_addr_o, rd_data_o);
        end
        step();
        mdu_data_i = 32'h0000_0046;
        #1;
        checks++;
        if (regw_en_o !== 1'b1 || rd_addr_o !== 5'd4 || rd_data_o !== 32'h44) begin
            failures++;
            $display("FAIL rr_wr_x4 got en=%b addr=%0d data=%h exp 1/4/44", regw_en_o, rd_addr_o, rd_data_o);
        end
        checks++;
        if (lsu_ready_o !== 1'b1 || mdu_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL rr_third got lsu=%b mdu=%b exp 1/0", lsu_ready_o, mdu_ready_o);
        end
        step();
        idle_inputs();
        checks++;
        if (regw_en_o !== 1'b1 || rd_addr_o !== 5'd3 || rd_data_o !== 32'h35) begin
            failures++;
            $display("FAIL rr_wr_x3b got en=%b addr=%0d data=%h exp 1/3/35", regw_en_o, rd_addr_o, rd_data_o);
        end
        step();
    endtask

    task automatic test_starve();
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd7; lsu_data_i = 32'h77;
        alu_valid_i = 1'b1; alu_rd_i = 5'd1;
        for (int i = 0; i < 4; i++) begin
            alu_data_i = 32'h100 + 32'(i);
            #1;
            checks++;
            if (alu_ready_o !== 1'b1 || lsu_ready_o !== 1'b0) begin
                failures++;
                $display("FAIL starve_alu%0d got alu=%b lsu=%b exp 1/0", i, alu_ready_o, lsu_ready_o);
            end
            step();
        end
        #1;
        checks++;
        if (alu_ready_o !== 1'b0 || lsu_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL starve_flag got alu=%b lsu=%b exp 0/1", alu_ready_o, lsu_ready_o);
        end
        checks++;
        if (rd_addr_o !== 5'd1 || rd_data_o !== 32'h103) begin
            failures++;
            $display("FAIL starve_last_alu got addr=%0d data=%h exp 1/103", rd_addr_o, rd_data_o);
        end
        step();
        lsu_valid_i = 1'b0;
        #1;
        checks++;
        if (regw_en_o !== 1'b1 || rd_addr_o !== 5'd7 || rd_data_o !== 32'h77) begin
            failures++;
            $display("FAIL starve_lsu_wr got en=%b addr=%0d data=%h exp 1/7/77", regw_en_o, rd_addr_o, rd_data_o);
        end
        checks++;
        if (alu_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL starve_clear got alu_ready=%b exp 1", alu_ready_o);
        end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_scoreboard();
        busy_set_i = 1'b1; busy_rd_i = 5'd9;
        step();
        busy_set_i = 1'b0;
        rs1_addr_i = 5'd9; rs2_addr_i = 5'd2;
        #1;
        checks++;
        if (busy_vec_o !== 32'h0000_0200 || dup_err_o !== 1'b0 || rs_busy_o !== 1'b1) begin
            failures++;
            $display("FAIL sb_set got busy=%h dup=%b rs=%b exp 00000200/0/1", busy_vec_o, dup_err_o, rs_busy_o);
        end
        rs1_addr_i = 5'd2; rs2_addr_i = 5'd8;
        #1;
        checks++;
        if (rs_busy_o !== 1'b0) begin
            failures++;
            $display("FAIL sb_rs_clear got %b exp 0", rs_busy_o);
        end
        busy_set_i = 1'b1; busy_rd_i = 5'd9;
        step();
        busy_set_i = 1'b0;
        checks++;
        if (dup_err_o !== 1'b1 || busy_vec_o[9] !== 1'b1) begin
            failures++;
            $display("FAIL sb_dup got dup=%b bit9=%b exp 1/1", dup_err_o, busy_vec_o[9]);
        end
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd9; lsu_data_i = 32'h9999;
        step();
        lsu_valid_i = 1'b0;
        checks++;
        if (dup_err_o !== 1'b0 || busy_vec_o !== 32'd0 || regw_en_o !== 1'b1 || rd_addr_o !== 5'd9) begin
            failures++;
            $display("FAIL sb_clear got dup=%b busy=%h en=%b addr=%0d exp 0/0/1/9", dup_err_o, busy_vec_o, regw_en_o, rd_addr_o);
        end
        step();
    endtask

    task automatic test_set_clear_same();
        busy_set_i = 1'b1; busy_rd_i = 5'd12;
        step();
        // Re-issue x12 in the same cycle its MDU result retires.
        mdu_valid_i = 1'b1; mdu_rd_i = 5'd12; mdu_data_i = 32'hC0DE_0012;
        #1;
        checks++;
        if (mdu_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL sc_ready got %b exp 1", mdu_ready_o);
        end
        step();
        idle_inputs();
        checks++;
        if (busy_vec_o !== 32'h0000_1000 || dup_err_o !== 1'b0) begin
            failures++;
            $display("FAIL sc_setwins got busy=%h dup=%b exp 00001000/0", busy_vec_o, dup_err_o);
        end
        checks++;
        if (regw_en_o !== 1'b1 || rd_addr_o !== 5'd12 || rd_data_o !== 32'hC0DE_0012) begin
            failures++;
            $display("FAIL sc_write got en=%b addr=%0d data=%h exp 1/12/c0de0012", regw_en_o, rd_addr_o, rd_data_o);
        end
        mdu_valid_i = 1'b1;
        step();
        mdu_valid_i = 1'b0;
        checks++;
        if (busy_vec_o !== 32'd0) begin
            failures++;
            $display("FAIL sc_final got busy=%h exp 0", busy_vec_o);
        end
        step();
    endtask

    task automatic test_x0();
        alu_valid_i = 1'b1; alu_rd_i = 5'd0; alu_data_i = 32'h1234_5678;
        busy_set_i = 1'b1; busy_rd_i = 5'd0;
        #1;
        checks++;
        if (alu_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL x0_ready got %b exp 1", alu_ready_o);
        end
        step();
        idle_inputs();
        checks++;
        if (regw_en_o !== 1'b0 || busy_vec_o !== 32'd0 || dup_err_o !== 1'b0) begin
            failures++;
            $display("FAIL x0_nowrite got en=%b busy=%h dup=%b exp 0/0/0", regw_en_o, busy_vec_o, dup_err_o);
        end
        step();
    endtask

    task automatic test_reset_mid();
        busy_set_i = 1'b1; busy_rd_i = 5'd20;
        step();
        busy_set_i = 1'b1; busy_rd_i = 5'd21;
        alu_valid_i = 1'b1; alu_rd_i = 5'd6; alu_data_i = 32'hABCD_0006;
        step();
        checks++;
        if (regw_en_o !== 1'b1 || busy_vec_o !== 32'h0030_0000) begin
            failures++;
            $display("FAIL rm_pre got en=%b busy=%h exp 1/00300000", regw_en_o, busy_vec_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (regw_en_o !== 1'b0 || rd_addr_o !== 5'd0 || rd_data_o !== 32'd0 || busy_vec_o !== 32'd0) begin
            failures++;
            $display("FAIL rm_async got en=%b addr=%0d data=%h busy=%h exp all 0", regw_en_o, rd_addr_o, rd_data_o, busy_vec_o);
        end
        idle_inputs();
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (busy_vec_o !== 32'd0 || regw_en_o !== 1'b0 || dup_err_o !== 1'b0) begin
            failures++;
            $display("FAIL rm_after got busy=%h en=%b dup=%b exp 0/0/0", busy_vec_o, regw_en_o, dup_err_o);
        end
    endtask

    initial begin
        test_reset();
        test_alu_only();
        test_lsu_mdu_rr();
        test_starve();
        test_scoreboard();
        test_set_clear_same();
        test_x0();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
